// File: rtl/wb_arb_pkg.sv
// Shared definitions for the three-master Wishbone round-robin arbiter:
// FSM state encoding, master index constants and the rotation helper.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_ERR   = 2'd2
  } arb_state_t;

  localparam int unsigned M_LM32I = 0;
  localparam int unsigned M_LM32D = 1;
  localparam int unsigned M_CAM   = 2;
  localparam int unsigned WDOG_W  = 8;

  // Priority pointer after the given one-hot owner releases: owner+1 mod 3.
  function automatic logic [1:0] next_prio(input logic [2:0] gnt);
    logic [1:0] p;
    p = 2'(M_LM32I);
    case (gnt)
      3'b001:  p = 2'(M_LM32D);
      3'b010:  p = 2'(M_CAM);
      default: p = 2'(M_LM32I);
    endcase
    return p;
  endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational 3-way rotating priority encoder: scans req from prio,
// prio+1, prio+2 (mod 3) and returns the first requester one-hot.
module wb_rr_pick
  import wb_arb_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] prio,
  output logic [2:0] gnt,
  output logic       valid
);

  always_comb begin
    gnt   = '0;
    valid = |req;
    case (prio)
      2'd1: begin
        if      (req[1]) gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
      end
      2'd2: begin
        if      (req[2]) gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
      end
      // prio 3 never occurs; it falls back to the reset scan order.
      default: begin
        if      (req[0]) gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
      end
    endcase
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Three-master round-robin Wishbone arbiter (lm32i, lm32d, cam DMA) with a
// held-for-cycle grant and a stall watchdog that returns err to the owner.
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned adr_width      = 32,
  parameter int unsigned timeout_cycles = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [adr_width-1:0] m0_adr_i,
  input  logic [31:0]          m0_dat_i,
  output logic [31:0]          m0_dat_o,
  input  logic [3:0]           m0_sel_i,
  input  logic                 m0_we_i,
  input  logic                 m0_cyc_i,
  input  logic                 m0_stb_i,
  output logic                 m0_ack_o,
  output logic                 m0_err_o,
  input  logic [adr_width-1:0] m1_adr_i,
  input  logic [31:0]          m1_dat_i,
  output logic [31:0]          m1_dat_o,
  input  logic [3:0]           m1_sel_i,
  input  logic                 m1_we_i,
  input  logic                 m1_cyc_i,
  input  logic                 m1_stb_i,
  output logic                 m1_ack_o,
  output logic                 m1_err_o,
  input  logic [adr_width-1:0] m2_adr_i,
  input  logic [31:0]          m2_dat_i,
  output logic [31:0]          m2_dat_o,
  input  logic [3:0]           m2_sel_i,
  input  logic                 m2_we_i,
  input  logic                 m2_cyc_i,
  input  logic                 m2_stb_i,
  output logic                 m2_ack_o,
  output logic                 m2_err_o,
  output logic [adr_width-1:0] s_adr_o,
  output logic [31:0]          s_dat_o,
  output logic [3:0]           s_sel_o,
  output logic                 s_we_o,
  output logic                 s_cyc_o,
  output logic                 s_stb_o,
  input  logic [31:0]          s_dat_i,
  input  logic                 s_ack_i,
  output logic [2:0]           gnt_o,
  output logic                 timeout_o
);

  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(timeout_cycles - 1);

  arb_state_t        state_q, state_d;
  logic [2:0]        gnt_q, gnt_d;
  logic [1:0]        prio_q, prio_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;

  logic [2:0]           pick_gnt;
  logic                 pick_valid;
  logic [adr_width-1:0] own_adr;
  logic [31:0]          own_dat;
  logic [3:0]           own_sel;
  logic                 own_we, own_cyc, own_stb;
  logic                 in_grant, in_err;

  wb_rr_pick u_pick (
    .req   ({m2_cyc_i, m1_cyc_i, m0_cyc_i}),
    .prio  (prio_q),
    .gnt   (pick_gnt),
    .valid (pick_valid)
  );

  always_comb begin
    own_adr = '0;
    own_dat = '0;
    own_sel = '0;
    own_we  = 1'b0;
    own_cyc = 1'b0;
    own_stb = 1'b0;
    unique case (gnt_q)
      3'b001: begin
        own_adr = m0_adr_i; own_dat = m0_dat_i; own_sel = m0_sel_i;
        own_we  = m0_we_i;  own_cyc = m0_cyc_i; own_stb = m0_stb_i;
      end
      3'b010: begin
        own_adr = m1_adr_i; own_dat = m1_dat_i; own_sel = m1_sel_i;
        own_we  = m1_we_i;  own_cyc = m1_cyc_i; own_stb = m1_stb_i;
      end
      3'b100: begin
        own_adr = m2_adr_i; own_dat = m2_dat_i; own_sel = m2_sel_i;
        own_we  = m2_we_i;  own_cyc = m2_cyc_i; own_stb = m2_stb_i;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    prio_d  = prio_q;
    wdog_d  = wdog_q;
    case (state_q)
      ST_IDLE: begin
        wdog_d = '0;
        if (pick_valid) begin
          gnt_d   = pick_gnt;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (!own_cyc) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          prio_d  = next_prio(gnt_q);
          wdog_d  = '0;
        end else if (own_stb && !s_ack_i) begin
          // An ack on the threshold cycle skips this branch, so ack beats err.
          if (wdog_q == WDOG_LAST) begin
            state_d = ST_ERR;
            wdog_d  = '0;
          end else begin
            wdog_d = wdog_q + 1'b1;
          end
        end else begin
          wdog_d = '0;
        end
      end
      ST_ERR: begin
        state_d = ST_GRANT;
        wdog_d  = '0;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        wdog_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      prio_q  <= '0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      prio_q  <= prio_d;
      wdog_q  <= wdog_d;
    end
  end

  assign in_grant = (state_q == ST_GRANT);
  assign in_err   = (state_q == ST_ERR);

  assign s_adr_o = own_adr;
  assign s_dat_o = own_dat;
  assign s_sel_o = own_sel;
  assign s_we_o  = own_we  & in_grant;
  assign s_cyc_o = own_cyc & in_grant;
  assign s_stb_o = own_stb & in_grant;

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m2_dat_o = s_dat_i;

  assign m0_ack_o = s_ack_i & gnt_q[M_LM32I] & in_grant;
  assign m1_ack_o = s_ack_i & gnt_q[M_LM32D] & in_grant;
  assign m2_ack_o = s_ack_i & gnt_q[M_CAM]   & in_grant;
  assign m0_err_o = gnt_q[M_LM32I] & in_err;
  assign m1_err_o = gnt_q[M_LM32D] & in_err;
  assign m2_err_o = gnt_q[M_CAM]   & in_err;

  assign gnt_o     = gnt_q;
  assign timeout_o = in_err;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Scoreboard bench for wb_rr_arbiter: masters push expected responses in
// predicted grant order; a negedge monitor pops and compares each ack/err.
module tb_wb_rr_arbiter;

  localparam int unsigned TMO = 8;

  typedef struct {
    int          m;
    logic [31:0] adr;
    logic        err;
  } exp_t;

  logic        clk, reset;
  logic [31:0] m_adr[3];
  logic [31:0] m_dat[3];
  logic [31:0] m_dato[3];
  logic [3:0]  m_sel[3];
  logic [2:0]  m_we, m_cyc, m_stb, m_ack, m_err;
  logic [31:0] s_adr_o, s_dat_o, s_dat_i;
  logic [3:0]  s_sel_o;
  logic        s_we_o, s_cyc_o, s_stb_o, s_ack_i;
  logic [2:0]  gnt;
  logic        timeout;

  exp_t sb[$];
  int   n_tests, n_fail;
  int   resp_count[3];
  int   tmo_cnt, stall_run, slv_cnt, slv_lat;
  logic [2:0] prev_gnt;
  int   mon_idx;
  exp_t mon_e;

  wb_rr_arbiter #(.adr_width(32), .timeout_cycles(TMO)) dut (
    .clk(clk), .reset(reset),
    .m0_adr_i(m_adr[0]), .m0_dat_i(m_dat[0]), .m0_dat_o(m_dato[0]), .m0_sel_i(m_sel[0]),
    .m0_we_i(m_we[0]), .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]), .m0_ack_o(m_ack[0]), .m0_err_o(m_err[0]),
    .m1_adr_i(m_adr[1]), .m1_dat_i(m_dat[1]), .m1_dat_o(m_dato[1]), .m1_sel_i(m_sel[1]),
    .m1_we_i(m_we[1]), .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]), .m1_ack_o(m_ack[1]), .m1_err_o(m_err[1]),
    .m2_adr_i(m_adr[2]), .m2_dat_i(m_dat[2]), .m2_dat_o(m_dato[2]), .m2_sel_i(m_sel[2]),
    .m2_we_i(m_we[2]), .m2_cyc_i(m_cyc[2]), .m2_stb_i(m_stb[2]), .m2_ack_o(m_ack[2]), .m2_err_o(m_err[2]),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .gnt_o(gnt), .timeout_o(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input logic [2:0] g, input string tag);
    for (int t = 0; t < 60 && gnt !== g; t++) step();
    chk(tag, 64'(gnt), 64'(g));
  endtask

  // One master transaction of `beats` acks (or a single err); returns one
  // cycle after releasing cyc so the arbiter sees the drop.
  task automatic xfer(input int m, input logic [31:0] adr, input int beats, input logic we);
    int base, got;
    m_adr[m] = adr;
    m_dat[m] = $urandom;
    m_sel[m] = 4'hf;
    m_we[m]  = we;
    m_cyc[m] = 1'b1;
    m_stb[m] = 1'b1;
    base = resp_count[m];
    got  = 0;
    for (int t = 0; t < 400 && got < beats; t++) begin
      step();
      if (resp_count[m] != base) begin
        base = resp_count[m];
        got++;
        m_adr[m] = m_adr[m] + 32'd4;
        m_dat[m] = $urandom;
        if (sb.size() == 0 && got < beats) got = beats;
      end
    end
    chk("xfer_done", 64'(got), 64'(beats));
    m_cyc[m] = 1'b0;
    m_stb[m] = 1'b0;
    step();
  endtask

  // Slave: ack after slv_lat stb cycles (0 = never), driven just after the edge.
  initial begin
    s_ack_i = 1'b0;
    s_dat_i = '0;
    slv_cnt = 0;
    forever begin
      @(posedge clk);
      #2;
      if (s_ack_i) begin
        s_ack_i = 1'b0;
        slv_cnt = 0;
      end
      if (reset || !(s_cyc_o && s_stb_o)) begin
        slv_cnt = 0;
      end else begin
        slv_cnt++;
        if (slv_lat > 0 && slv_cnt >= slv_lat) begin
          s_ack_i = 1'b1;
          s_dat_i = $urandom;
        end
      end
    end
  end

  initial begin
    prev_gnt  = '0;
    stall_run = 0;
    tmo_cnt   = 0;
    for (int i = 0; i < 3; i++) resp_count[i] = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if ((m_ack | m_err) != 3'b000) begin
          mon_idx = (m_ack[1] | m_err[1]) ? 1 : (m_ack[2] | m_err[2]) ? 2 : 0;
          chk("resp_onehot", 64'($countones(m_ack | m_err)), 64'd1);
          if (sb.size() == 0) begin
            chk("resp_expected", 64'd0, 64'd1);
          end else begin
            mon_e = sb.pop_front();
            chk("resp_master", 64'(mon_idx), 64'(mon_e.m));
            chk("resp_err", 64'(m_err[mon_idx]), 64'(mon_e.err));
            chk("resp_adr", 64'(s_adr_o), 64'(mon_e.adr));
            chk("resp_gnt", 64'(gnt), 64'(3'b001 << mon_e.m));
            chk("resp_rdat", 64'(m_dato[mon_idx]), 64'(s_dat_i));
            chk("resp_wdat", 64'(s_dat_o), 64'(m_dat[mon_idx]));
            if (mon_e.err) chk("err_stalls", 64'(stall_run), 64'(TMO));
          end
          resp_count[mon_idx]++;
        end
        if (timeout) begin
          tmo_cnt++;
          chk("err_bus_idle", 64'({s_cyc_o, s_stb_o}), 64'd0);
          chk("err_no_ack", 64'(m_ack), 64'd0);
        end
        if (s_cyc_o && s_stb_o && !s_ack_i) stall_run++;
        else stall_run = 0;
        if (gnt != 3'b000 && gnt != prev_gnt) chk("turnaround", 64'(prev_gnt), 64'd0);
      end else begin
        stall_run = 0;
      end
      prev_gnt = gnt;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    int base0, base1, base2, tmo_base;
    n_tests = 0;
    n_fail  = 0;
    slv_lat = 2;
    reset   = 1'b1;
    m_cyc   = '0;
    m_stb   = '0;
    m_we    = '0;
    for (int i = 0; i < 3; i++) begin
      m_adr[i] = '0;
      m_dat[i] = '0;
      m_sel[i] = '0;
    end
    step();
    step();
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_cyc_stb_we", 64'({s_cyc_o, s_stb_o, s_we_o}), 64'd0);
    chk("rst_ack", 64'(m_ack), 64'd0);
    chk("rst_err", 64'(m_err), 64'd0);
    chk("rst_timeout", 64'(timeout), 64'd0);
    reset = 1'b0;
    step();

    // m1 alone, slave acks on the 2nd stb cycle
    base0 = resp_count[0]; base1 = resp_count[1]; base2 = resp_count[2];
    sb.push_back('{m: 1, adr: 32'h2000_0000, err: 1'b0});
    fork
      xfer(1, 32'h2000_0000, 1, 1'b0);
      begin
        #1;
        chk("t1_gnt_pre", 64'(gnt), 64'd0);
        step();
        chk("t1_gnt_lat", 64'(gnt), 64'b010);
      end
    join
    chk("t1_m1_acks", 64'(resp_count[1] - base1), 64'd1);
    chk("t1_m0m2_acks", 64'((resp_count[0] - base0) + (resp_count[2] - base2)), 64'd0);

    // all three from reset: order 0,1,2 then m0 again
    reset = 1'b1;
    step();
    reset = 1'b0;
    slv_lat = 1;
    sb.push_back('{m: 0, adr: 32'h0000_1000, err: 1'b0});
    sb.push_back('{m: 1, adr: 32'h1000_1000, err: 1'b0});
    sb.push_back('{m: 2, adr: 32'h2000_1000, err: 1'b0});
    sb.push_back('{m: 0, adr: 32'h0000_2000, err: 1'b0});
    fork
      begin
        xfer(0, 32'h0000_1000, 1, 1'b0);
        xfer(0, 32'h0000_2000, 1, 1'b1);
      end
      xfer(1, 32'h1000_1000, 1, 1'b1);
      xfer(2, 32'h2000_1000, 1, 1'b0);
    join
    chk("t2_sb_drained", 64'(sb.size()), 64'd0);

    // m2 4-beat burst; m0 requests mid-burst and must wait
    for (int b = 0; b < 4; b++)
      sb.push_back('{m: 2, adr: 32'h3000_0000 + 32'(4 * b), err: 1'b0});
    sb.push_back('{m: 0, adr: 32'h0000_3000, err: 1'b0});
    fork
      xfer(2, 32'h3000_0000, 4, 1'b1);
      begin
        wait_gnt(3'b100, "t3_m2_gnt");
        xfer(0, 32'h0000_3000, 1, 1'b0);
      end
    join
    chk("t3_sb_drained", 64'(sb.size()), 64'd0);

    // slave never acks: err after TMO stall cycles
    slv_lat  = 0;
    tmo_base = tmo_cnt;
    sb.push_back('{m: 0, adr: 32'h0000_4000, err: 1'b1});
    xfer(0, 32'h0000_4000, 1, 1'b0);
    chk("t4_tmo_pulses", 64'(tmo_cnt - tmo_base), 64'd1);

    // ack exactly on the last stall cycle wins over the watchdog
    slv_lat  = TMO;
    tmo_base = tmo_cnt;
    sb.push_back('{m: 0, adr: 32'h0000_5000, err: 1'b0});
    xfer(0, 32'h0000_5000, 1, 1'b0);
    chk("t5_tmo_quiet", 64'(tmo_cnt - tmo_base), 64'd0);

    // reset during an m1 transfer; next arbitration scans from m0
    slv_lat  = 0;
    m_adr[1] = 32'h2000_0040;
    m_sel[1] = 4'hf;
    m_cyc[1] = 1'b1;
    m_stb[1] = 1'b1;
    wait_gnt(3'b010, "t6_m1_gnt");
    step();
    reset    = 1'b1;
    m_cyc[1] = 1'b0;
    m_stb[1] = 1'b0;
    step();
    chk("t6_rst_gnt", 64'(gnt), 64'd0);
    chk("t6_rst_cyc", 64'(s_cyc_o), 64'd0);
    reset   = 1'b0;
    slv_lat = 1;
    sb.push_back('{m: 0, adr: 32'h0000_6000, err: 1'b0});
    sb.push_back('{m: 2, adr: 32'h2000_6000, err: 1'b0});
    fork
      xfer(0, 32'h0000_6000, 1, 1'b0);
      xfer(2, 32'h2000_6000, 1, 1'b0);
    join
    chk("final_sb_drained", 64'(sb.size()), 64'd0);

    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
